// File: rtl/island_readback_ctrl.sv
// Readback engine for one CAB island scan chain: captures switch state, shifts it out
// serially and packs it LSB-first into WORD_W-bit words on a valid/ready stream.
module island_readback_ctrl #(
   parameter int NUM_CAB    = 7,
   parameter int MATRIX_ROW = 7,
   parameter int MATRIX_COL = 1,
   parameter int WORD_W     = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic              busy,
   output logic              scan_capture,
   output logic              scan_shift,
   input  logic              scan_in,
   output logic [WORD_W-1:0] m_data,
   output logic              m_valid,
   input  logic              m_ready,
   output logic              m_last,
   output logic              done
);

   localparam int TOTAL_BITS = NUM_CAB * MATRIX_ROW * MATRIX_COL;
   localparam int CNT_W      = $clog2(TOTAL_BITS + 1);
   localparam int POS_W      = $clog2(WORD_W);

   typedef enum logic [2:0] {IDLE, CAPTURE, SHIFT, DRAIN, DONE} state_t;

   state_t            state_reg, state_next;
   logic [CNT_W-1:0]  count_reg, count_next;
   logic [POS_W-1:0]  pos_reg, pos_next;
   logic [WORD_W-1:0] pack_reg, pack_next;
   logic              pack_full_reg, pack_full_next;
   logic              pack_last_reg, pack_last_next;
   logic [WORD_W-1:0] data_reg, data_next;
   logic              valid_reg, valid_next;
   logic              last_reg, last_next;

   logic              out_free;
   logic              final_bit;
   logic [WORD_W-1:0] word;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= IDLE;
         count_reg     <= '0;
         pos_reg       <= '0;
         pack_reg      <= '0;
         pack_full_reg <= 1'b0;
         pack_last_reg <= 1'b0;
         data_reg      <= '0;
         valid_reg     <= 1'b0;
         last_reg      <= 1'b0;
      end else begin
         state_reg     <= state_next;
         count_reg     <= count_next;
         pos_reg       <= pos_next;
         pack_reg      <= pack_next;
         pack_full_reg <= pack_full_next;
         pack_last_reg <= pack_last_next;
         data_reg      <= data_next;
         valid_reg     <= valid_next;
         last_reg      <= last_next;
      end
   end

   always_comb begin
      state_next     = state_reg;
      count_next     = count_reg;
      pos_next       = pos_reg;
      pack_next      = pack_reg;
      pack_full_next = pack_full_reg;
      pack_last_next = pack_last_reg;
      data_next      = data_reg;
      valid_next     = valid_reg;
      last_next      = last_reg;
      busy           = 1'b0;
      scan_capture   = 1'b0;
      scan_shift     = 1'b0;
      done           = 1'b0;
      word           = pack_reg;
      final_bit      = (count_reg == CNT_W'(TOTAL_BITS - 1));
      out_free       = !valid_reg || m_ready;

      if (valid_reg && m_ready) begin
         valid_next = 1'b0;
         last_next  = 1'b0;
      end

      // A word parked in the pack register goes out as soon as the output slot frees.
      if ((state_reg == SHIFT || state_reg == DRAIN) && pack_full_reg && out_free) begin
         data_next      = pack_reg;
         valid_next     = 1'b1;
         last_next      = pack_last_reg;
         pack_next      = '0;
         pack_full_next = 1'b0;
         pack_last_next = 1'b0;
      end

      case (state_reg)
         IDLE: begin
            if (start) state_next = CAPTURE;
         end
         CAPTURE: begin
            busy           = 1'b1;
            scan_capture   = 1'b1;
            count_next     = '0;
            pos_next       = '0;
            pack_next      = '0;
            pack_full_next = 1'b0;
            pack_last_next = 1'b0;
            state_next     = SHIFT;
         end
         SHIFT: begin
            busy = 1'b1;
            if (!pack_full_reg) begin
               scan_shift    = 1'b1;
               word[pos_reg] = scan_in;
               count_next    = count_reg + CNT_W'(1);
               if (final_bit || pos_reg == POS_W'(WORD_W - 1)) begin
                  pos_next = '0;
                  if (out_free) begin
                     data_next  = word;
                     valid_next = 1'b1;
                     last_next  = final_bit;
                     pack_next  = '0;
                  end else begin
                     pack_next      = word;
                     pack_full_next = 1'b1;
                     pack_last_next = final_bit;
                  end
               end else begin
                  pos_next  = pos_reg + POS_W'(1);
                  pack_next = word;
               end
               if (final_bit) state_next = DRAIN;
            end
         end
         DRAIN: begin
            busy = 1'b1;
            if (valid_reg && m_ready && last_reg) state_next = DONE;
         end
         DONE: begin
            done       = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   assign m_data  = data_reg;
   assign m_valid = valid_reg;
   assign m_last  = last_reg;

endmodule

// File: tb/tb_island_readback_ctrl.sv
// Directed bench for island_readback_ctrl: default island plus a 16-bit / 2-CAB variant.
module tb_island_readback_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       busy, scan_capture, scan_shift, scan_in;
   logic [7:0] m_data;
   logic       m_valid, m_last, done;
   logic       m_ready = 1'b1;

   logic        start2 = 1'b0;
   logic        busy2, scan_capture2, scan_shift2, m_valid2, m_last2, done2;
   logic        scan_in2 = 1'b1;
   logic        m_ready2 = 1'b1;
   logic [15:0] m_data2;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   island_readback_ctrl dut (
      .clk(clk), .rst(rst), .start(start), .busy(busy),
      .scan_capture(scan_capture), .scan_shift(scan_shift), .scan_in(scan_in),
      .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last), .done(done)
   );

   island_readback_ctrl #(.NUM_CAB(2), .MATRIX_ROW(7), .MATRIX_COL(1), .WORD_W(16)) dut2 (
      .clk(clk), .rst(rst), .start(start2), .busy(busy2),
      .scan_capture(scan_capture2), .scan_shift(scan_shift2), .scan_in(scan_in2),
      .m_data(m_data2), .m_valid(m_valid2), .m_ready(m_ready2), .m_last(m_last2), .done(done2)
   );

   // Chain model: capture rewinds to bit 0, each shift edge advances one bit.
   int   chain_idx = 0;
   logic all_ones = 1'b0;
   always @(posedge clk) begin
      if (scan_capture) chain_idx <= 0;
      else if (scan_shift) chain_idx <= chain_idx + 1;
   end
   assign scan_in = all_ones ? 1'b1 : chain_idx[0];

   logic [7:0] words [16];
   logic       lasts [16];
   int         wcyc  [16];
   logic       shift_at [128];
   int nwords, shifts, caps, cap_cyc, done_cyc, busy_first, busy_last, busy_cnt;
   int first_shift, last_shift, stable_viol;
   logic timed_out;
   logic [13:0] post_rst;

   logic [7:0] exp_alt [7] = '{8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'h00};
   logic [7:0] exp_one [7] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h01};

   // Runs one readback on the default DUT, recording observations per cycle.
   task automatic run(input int s1, input int s2, input int lo, input int hi, input int abort_at);
      logic       pv, pr, pl, fin;
      logic [7:0] pd;
      nwords = 0; shifts = 0; caps = 0; cap_cyc = -1; done_cyc = -1;
      busy_first = -1; busy_last = -1; busy_cnt = 0; first_shift = -1; last_shift = -1;
      stable_viol = 0; timed_out = 1'b0; fin = 1'b0;
      pv = 1'b0; pr = 1'b1; pl = 1'b0; pd = '0;
      for (int i = 0; i < 128; i++) shift_at[i] = 1'b0;
      @(negedge clk);
      start = 1'b1;
      m_ready = 1'b1;
      for (int rel = 1; rel <= 120; rel++) begin
         @(negedge clk);
         start   = (rel == s1) || (rel == s2);
         m_ready = !(rel >= lo && rel <= hi);
         if (abort_at > 0 && rel == abort_at) begin
            start = 1'b0;
            rst   = 1'b1;
         end
         if (abort_at > 0 && rel == abort_at + 1) begin
            rst      = 1'b0;
            post_rst = {busy, scan_capture, scan_shift, m_valid, m_last, done, m_data};
            fin      = 1'b1;
            break;
         end
         if (scan_capture) begin caps++; cap_cyc = rel; end
         if (scan_shift) begin
            shifts++;
            shift_at[rel] = 1'b1;
            if (first_shift < 0) first_shift = rel;
            last_shift = rel;
         end
         if (busy) begin
            busy_cnt++;
            if (busy_first < 0) busy_first = rel;
            busy_last = rel;
         end
         if (pv && !pr && m_valid && (m_data !== pd || m_last !== pl)) stable_viol++;
         if (pv && !pr && !m_valid) stable_viol++;
         if (m_valid && m_ready && nwords < 16) begin
            words[nwords] = m_data;
            lasts[nwords] = m_last;
            wcyc[nwords]  = rel;
            nwords++;
         end
         pv = m_valid; pr = m_ready; pd = m_data; pl = m_last;
         if (done) begin
            done_cyc = rel;
            fin      = 1'b1;
            break;
         end
      end
      if (!fin) timed_out = 1'b1;
      m_ready = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if ({busy, scan_capture, scan_shift, m_valid, m_last, done} !== 6'b0) begin
         errors++;
         $display("FAIL reset_ctrl: got %b want 000000", {busy, scan_capture, scan_shift, m_valid, m_last, done});
      end
      checks++;
      if (m_data !== 8'h00) begin
         errors++;
         $display("FAIL reset_data: got %h want 00", m_data);
      end
      rst = 1'b0;
      @(negedge clk);
      $display("reset: outputs idle after reset release");
   endtask

   task automatic test_alternating();
      all_ones = 1'b0;
      run(0, 0, 1000, 1000, 0);
      checks++;
      if (timed_out !== 1'b0) begin errors++; $display("FAIL alt_timeout: got %b want 0", timed_out); end
      checks++;
      if (caps != 1 || cap_cyc != 1) begin errors++; $display("FAIL alt_capture: got %0d at cycle %0d want 1 at 1", caps, cap_cyc); end
      checks++;
      if (shifts != 49 || first_shift != 2 || last_shift != 50) begin
         errors++;
         $display("FAIL alt_shifts: got %0d (%0d..%0d) want 49 (2..50)", shifts, first_shift, last_shift);
      end
      checks++;
      if (nwords != 7) begin errors++; $display("FAIL alt_nwords: got %0d want 7", nwords); end
      for (int i = 0; i < 7 && i < nwords; i++) begin
         checks++;
         if (words[i] !== exp_alt[i] || lasts[i] !== (i == 6) || wcyc[i] != ((i < 6) ? 10 + 8 * i : 51)) begin
            errors++;
            $display("FAIL alt_word%0d: got %h last=%b cyc=%0d want %h last=%b cyc=%0d", i, words[i], lasts[i],
                     wcyc[i], exp_alt[i], (i == 6), (i < 6) ? 10 + 8 * i : 51);
         end
         $display("alt word %0d: data=%h last=%b cycle=%0d", i, words[i], lasts[i], wcyc[i]);
      end
      checks++;
      if (done_cyc != 52) begin errors++; $display("FAIL alt_done: got cycle %0d want 52", done_cyc); end
      @(negedge clk);
   endtask

   task automatic test_all_ones();
      all_ones = 1'b1;
      run(0, 0, 1000, 1000, 0);
      all_ones = 1'b0;
      checks++;
      if (nwords != 7 || timed_out) begin errors++; $display("FAIL ones_nwords: got %0d want 7", nwords); end
      for (int i = 0; i < 7 && i < nwords; i++) begin
         checks++;
         if (words[i] !== exp_one[i] || lasts[i] !== (i == 6)) begin
            errors++;
            $display("FAIL ones_word%0d: got %h last=%b want %h last=%b", i, words[i], lasts[i], exp_one[i], (i == 6));
         end
         $display("ones word %0d: data=%h last=%b", i, words[i], lasts[i]);
      end
      checks++;
      if (busy_first != 1 || busy_last != 51 || busy_cnt != 51) begin
         errors++;
         $display("FAIL ones_busy: got %0d..%0d n=%0d want 1..51 n=51", busy_first, busy_last, busy_cnt);
      end
      checks++;
      if (done_cyc != 52) begin errors++; $display("FAIL ones_done: got cycle %0d want 52", done_cyc); end
      @(negedge clk);
   endtask

   task automatic test_backpressure();
      logic stall_ok;
      all_ones = 1'b0;
      run(0, 0, 10, 25, 0);
      stall_ok = shift_at[17];
      for (int c = 18; c <= 26; c++) if (shift_at[c]) stall_ok = 1'b0;
      checks++;
      if (stall_ok !== 1'b1) begin errors++; $display("FAIL bp_stall: got shift pattern bad want shift@17, none 18..26"); end
      checks++;
      if (stable_viol != 0) begin errors++; $display("FAIL bp_stable: got %0d changes want 0", stable_viol); end
      checks++;
      if (shifts != 49 || nwords != 7 || timed_out) begin
         errors++;
         $display("FAIL bp_counts: got shifts=%0d words=%0d want 49 7", shifts, nwords);
      end
      checks++;
      if (nwords < 1 || wcyc[0] != 26) begin errors++; $display("FAIL bp_accept0: got cycle %0d want 26", wcyc[0]); end
      for (int i = 0; i < 7 && i < nwords; i++) begin
         checks++;
         if (words[i] !== exp_alt[i] || lasts[i] !== (i == 6)) begin
            errors++;
            $display("FAIL bp_word%0d: got %h last=%b want %h last=%b", i, words[i], lasts[i], exp_alt[i], (i == 6));
         end
         $display("bp word %0d: data=%h last=%b cycle=%0d", i, words[i], lasts[i], wcyc[i]);
      end
      @(negedge clk);
   endtask

   task automatic test_ignored_start();
      all_ones = 1'b0;
      run(5, 30, 1000, 1000, 0);
      checks++;
      if (caps != 1 || nwords != 7 || done_cyc != 52) begin
         errors++;
         $display("FAIL ign_run1: got caps=%0d words=%0d done=%0d want 1 7 52", caps, nwords, done_cyc);
      end
      $display("ignored start: caps=%0d words=%0d done=%0d", caps, nwords, done_cyc);
      // Back-to-back readback starting in the cycle after done, with a start pulse inside DONE.
      run(0, 52, 1000, 1000, 0);
      checks++;
      if (caps != 1 || nwords != 7 || done_cyc != 52 || words[3] !== 8'hAA || lasts[6] !== 1'b1) begin
         errors++;
         $display("FAIL ign_run2: got caps=%0d words=%0d done=%0d w3=%h want 1 7 52 aa", caps, nwords, done_cyc, words[3]);
      end
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (busy !== 1'b0 || scan_capture !== 1'b0) begin
         errors++;
         $display("FAIL ign_done_start: got busy=%b cap=%b want 0 0", busy, scan_capture);
      end
      $display("second readback: caps=%0d words=%0d done=%0d", caps, nwords, done_cyc);
      @(negedge clk);
   endtask

   task automatic test_reset_abort();
      all_ones = 1'b0;
      run(0, 0, 1000, 1000, 20);
      checks++;
      if (post_rst !== 14'b0) begin errors++; $display("FAIL abort_outputs: got %b want all 0", post_rst); end
      run(0, 0, 1000, 1000, 0);
      checks++;
      if (caps != 1 || shifts != 49 || nwords != 7 || done_cyc != 52) begin
         errors++;
         $display("FAIL abort_rerun: got caps=%0d shifts=%0d words=%0d done=%0d want 1 49 7 52", caps, shifts, nwords, done_cyc);
      end
      for (int i = 0; i < 7 && i < nwords; i++) begin
         checks++;
         if (words[i] !== exp_alt[i]) begin
            errors++;
            $display("FAIL abort_word%0d: got %h want %h", i, words[i], exp_alt[i]);
         end
      end
      $display("reset abort: rerun words=%0d done=%0d", nwords, done_cyc);
      @(negedge clk);
   endtask

   task automatic test_wide();
      int n = 0, sh = 0, dc = -1;
      logic [15:0] w = '0;
      logic l = 1'b0;
      @(negedge clk);
      start2 = 1'b1;
      for (int rel = 1; rel <= 60; rel++) begin
         @(negedge clk);
         start2 = 1'b0;
         if (scan_shift2) sh++;
         if (m_valid2 && m_ready2) begin n++; w = m_data2; l = m_last2; end
         if (done2) begin dc = rel; break; end
      end
      checks++;
      if (n != 1 || w !== 16'h3FFF || l !== 1'b1) begin
         errors++;
         $display("FAIL wide_word: got n=%0d %h last=%b want 1 3fff 1", n, w, l);
      end
      checks++;
      if (sh != 14 || dc != 17) begin errors++; $display("FAIL wide_timing: got shifts=%0d done=%0d want 14 17", sh, dc); end
      $display("wide: data=%h last=%b shifts=%0d done=%0d", w, l, sh, dc);
   endtask

   initial begin
      test_reset();
      test_alternating();
      test_all_ones();
      test_backpressure();
      test_ignored_start();
      test_reset_abort();
      test_wide();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/island_readback_ctrl.md
Name: island_readback_ctrl

Overview:
- Readback engine for the CAB island switch-matrix scan chain. It is the reverse direction of the programming path: it captures the programmed switch state into the chain and shifts it out serially.
- Incoming bits are packed into WORD_W-bit words and delivered to the host over a valid/ready stream with backpressure.
- Sits beside the programming mux at fabric top and covers one island: NUM_CAB CABs, each with MATRIX_ROW x MATRIX_COL switches.

Parameters:
- NUM_CAB, 7, CABs chained in the island.
- MATRIX_ROW, 7, switch-matrix rows per CAB.
- MATRIX_COL, 1, switch-matrix columns per CAB.
- WORD_W, 8, output word width in bits (≥2).
- Derived: TOTAL_BITS = NUM_CAB*MATRIX_ROW*MATRIX_COL (49 at defaults); NUM_WORDS = ceil(TOTAL_BITS/WORD_W) (7 at defaults).

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous reset, active-high.
- start  in  1  request readback; sampled only in IDLE.
- busy  out  1  high from the cycle after an accepted start until DONE.
- scan_capture  out  1  one-cycle pulse; chain parallel-loads switch state.
- scan_shift  out  1  chain advances one position at each clk edge where this is high.
- scan_in  in  1  chain serial output; valid while scan_shift=1.
- m_data  out  WORD_W  packed readback word.
- m_valid  out  1  m_data valid.
- m_ready  in  1  host accepts the word.
- m_last  out  1  qualifies the final word (with m_valid).
- done  out  1  one-cycle pulse at completion.

Behaviour:
- Reset values: all outputs 0, pack register 0, bit counter 0, state IDLE. Reset mid-operation aborts immediately: outputs are 0 on the next cycle and any partial word is discarded. A chain left mid-shift is harmless because the next readback begins with a capture.
- States: IDLE -> CAPTURE -> SHIFT -> DRAIN -> DONE -> IDLE.
- IDLE:
  - start=1 -> CAPTURE.
  - start in any other state is ignored; no queuing.
- CAPTURE:
  - Exactly one cycle with scan_capture=1 and scan_shift=0.
  - Clear the bit counter and pack register, then go to SHIFT.
- SHIFT:
  - When shifting is allowed, scan_shift=1 and scan_in is written into pack bit (count mod WORD_W) at the clock edge; the counter increments.
  - The first bit shifted out is stored at m_data[0] of word 0. Bits fill LSB-first and words are emitted in order.
- Word handoff:
  - A word is complete when WORD_W bits are packed or the final bit (count = TOTAL_BITS-1) is packed.
  - At that edge the word moves to the output register if the output register is empty or is being accepted that cycle (m_valid & m_ready). m_valid then rises on the next cycle.
  - If the output register is full and not accepted, the completed word is held in the pack register and scan_shift=0 (stall) until the output slot frees. No bit is ever dropped or duplicated.
  - Unused MSBs of the final partial word are 0.
- After the final bit is packed -> DRAIN: scan_shift=0; wait until the last word has been transferred and accepted (m_valid & m_ready & m_last).
- m_last=1 only with the final word's m_valid. m_data and m_last are stable while m_valid=1 and m_ready=0.
- DONE: done=1 for one cycle, busy=0 that cycle; next state is IDLE. A start in DONE is ignored.
- Exactly TOTAL_BITS scan_shift cycles occur per readback. Exactly NUM_WORDS handshakes occur.
- Latency (defaults, m_ready held 1, start accepted at edge of cycle 0):
  - cycle 1: CAPTURE.
  - cycles 2–50: SHIFT.
  - cycles 10, 18, …, 50: m_valid high for words 0–5.
  - cycle 51: m_valid high for word 6 with m_last.
  - cycle 52: done.

Test Plan:
- Alternating chain (bit k = k%2), m_ready=1, defaults -> words 0xAA ×6 then 0x00 with m_last. 49 scan_shift cycles; done in cycle 52; single scan_capture in cycle 1.
- All-ones chain -> words 0xFF ×6, final word 0x01 with m_last=1; busy high cycles 1–51.
- m_ready=0 during cycles 10–25, otherwise 1 -> word 0 (0xAA) held stable; shifting stalls once word 1 is packed (scan_shift low from cycle 18). Resumes after m_ready returns. Total shifts still 49, data identical to test 1.
- start pulsed at cycles 5 and 30 during a readback -> ignored; exactly one capture and 7 words; start after done runs a second full readback.
- rst asserted in cycle 20 -> cycle 21 all outputs 0, state IDLE; a new start gives a clean capture and a full 7-word readback.
- WORD_W=16, NUM_CAB=2 (14 bits), all-ones chain -> single word 0x3FFF with m_last; 14 shifts.
